// File: rtl/prod_bcd_converter.sv
// Sequential binary-to-BCD converter for the multiplier product path.
// Sign/magnitude split on start, then one double-dabble shift per clock.
module prod_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] prod,
    output logic             busy,
    output logic             done,
    output logic             neg,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       units
);

    generate
        if (WIDTH < 4 || WIDTH > 9) begin : g_bad_width
            $error("prod_bcd_converter: WIDTH must be in 4..9");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_shift;
    logic [11:0]      r_bcd;
    logic [3:0]       r_cnt;
    logic             r_sign;
    logic             r_busy, r_done, r_neg;
    logic [3:0]       r_hun, r_ten, r_uni;

    logic             w_sign;
    logic [WIDTH-1:0] w_mag;
    logic [11:0]      w_adj;

    // Negating the most negative code wraps to itself, which read unsigned is its magnitude.
    assign w_sign = SIGNED && prod[WIDTH-1];
    assign w_mag  = w_sign ? (~prod + {{(WIDTH-1){1'b0}}, 1'b1}) : prod;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_adj
            assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                                : r_bcd[4*g +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == 4'd1) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neg   <= 1'b0;
            r_hun   <= '0;
            r_ten   <= '0;
            r_uni   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_shift <= w_mag;
                    r_sign  <= w_sign;
                    r_bcd   <= '0;
                    r_cnt   <= 4'(WIDTH);
                    r_busy  <= 1'b1;
                end
                S_SHIFT: begin
                    r_bcd   <= {w_adj[10:0], r_shift[WIDTH-1]};
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt - 4'd1;
                end
                S_DONE: begin
                    r_hun  <= r_bcd[11:8];
                    r_ten  <= r_bcd[7:4];
                    r_uni  <= r_bcd[3:0];
                    r_neg  <= r_sign;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign neg      = r_neg;
    assign hundreds = r_hun;
    assign tens     = r_ten;
    assign units    = r_uni;

endmodule

// File: tb/tb_prod_bcd_converter.sv
// Directed bench for prod_bcd_converter: signed and unsigned WIDTH=8 instances.
module tb_prod_bcd_converter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s, start_u;
    logic [7:0] prod_s, prod_u;
    logic       busy_s, done_s, neg_s, busy_u, done_u, neg_u;
    logic [3:0] hun_s, ten_s, uni_s, hun_u, ten_u, uni_u;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prod_bcd_converter #(.WIDTH(8), .SIGNED(1'b1)) u_s (
        .clk(clk), .rst(rst), .start(start_s), .prod(prod_s),
        .busy(busy_s), .done(done_s), .neg(neg_s),
        .hundreds(hun_s), .tens(ten_s), .units(uni_s)
    );

    prod_bcd_converter #(.WIDTH(8), .SIGNED(1'b0)) u_u (
        .clk(clk), .rst(rst), .start(start_u), .prod(prod_u),
        .busy(busy_u), .done(done_u), .neg(neg_u),
        .hundreds(hun_u), .tens(ten_u), .units(uni_u)
    );

    // Caller sits 1 time unit after an edge with the block idle; returns 1 unit after E0.
    task automatic go_s(input logic [7:0] p);
        start_s = 1'b1; prod_s = p;
        @(posedge clk); #1;
        start_s = 1'b0; prod_s = ~p;
    endtask

    task automatic go_u(input logic [7:0] p);
        start_u = 1'b1; prod_u = p;
        @(posedge clk); #1;
        start_u = 1'b0; prod_u = ~p;
    endtask

    // Edges counted from E0 until done is seen; 40 means it never came.
    task automatic wait_done_s(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1; lat++;
            if (done_s) break;
        end
        if (!done_s) lat = 40;
    endtask

    task automatic wait_done_u(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1; lat++;
            if (done_u) break;
        end
        if (!done_u) lat = 40;
    endtask

    task automatic test_reset;
        rst = 1'b0; start_s = 1'b0; start_u = 1'b0; prod_s = 8'h5A; prod_u = 8'hA5;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({busy_s, done_s, neg_s, hun_s, ten_s, uni_s} !== 15'd0) begin
                n_err++;
                $display("FAIL reset_s cyc%0d got %b want 0", i, {busy_s, done_s, neg_s, hun_s, ten_s, uni_s});
            end
            n_vec++;
            if ({busy_u, done_u, neg_u, hun_u, ten_u, uni_u} !== 15'd0) begin
                n_err++;
                $display("FAIL reset_u cyc%0d got %b want 0", i, {busy_u, done_u, neg_u, hun_u, ten_u, uni_u});
            end
        end
    endtask

    task automatic test_latency;
        int lat;
        go_s(8'h38);
        n_vec++;
        if (busy_s !== 1'b1) begin n_err++; $display("FAIL lat_busy got %b want 1", busy_s); end
        wait_done_s(lat);
        n_vec++;
        if (lat != 9) begin n_err++; $display("FAIL lat_edges got %0d want 9", lat); end
        n_vec++;
        if ({busy_s, neg_s, hun_s, ten_s, uni_s} !== {1'b0, 1'b0, 4'd0, 4'd5, 4'd6}) begin
            n_err++; $display("FAIL lat_result got %h want 0056", {busy_s, neg_s, hun_s, ten_s, uni_s});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({done_s, busy_s} !== 2'b00) begin n_err++; $display("FAIL lat_done_width got %b want 00", {done_s, busy_s}); end
    endtask

    task automatic test_signed_vectors;
        logic [7:0]  p   [5] = '{8'hC8, 8'h80, 8'h40, 8'h00, 8'h7F};
        logic [12:0] exp [5] = '{{1'b1, 12'h056}, {1'b1, 12'h128}, {1'b0, 12'h064},
                                 {1'b0, 12'h000}, {1'b0, 12'h127}};
        int lat;
        for (int k = 0; k < 5; k++) begin
            go_s(p[k]);
            wait_done_s(lat);
            n_vec++;
            if (lat != 9 || {neg_s, hun_s, ten_s, uni_s} !== exp[k]) begin
                n_err++;
                $display("FAIL signed_%h got lat=%0d %h want lat=9 %h", p[k], lat, {neg_s, hun_s, ten_s, uni_s}, exp[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        go_s(8'h07);
        repeat (3) @(posedge clk);
        #0 start_s = 1'b1; prod_s = 8'h63;   // accepted at E4 if it were not ignored
        @(posedge clk); #1;
        start_s = 1'b0; prod_s = 8'h00;
        wait_done_s(lat);
        n_vec++;
        if (lat != 5 || {neg_s, hun_s, ten_s, uni_s} !== 13'h0007) begin
            n_err++; $display("FAIL busy_ignore got lat=%0d %h want lat=5 0007", lat, {neg_s, hun_s, ten_s, uni_s});
        end
        go_s(8'h63);                          // start in the done cycle
        wait_done_s(lat);
        n_vec++;
        if (lat != 9 || {neg_s, hun_s, ten_s, uni_s} !== 13'h0099) begin
            n_err++; $display("FAIL back_to_back got lat=%0d %h want lat=9 0099", lat, {neg_s, hun_s, ten_s, uni_s});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen = 0;
        go_s(8'h38);
        repeat (4) @(posedge clk);
        #0 rst = 1'b0;
        @(posedge clk); #1;                   // E5 with rst low
        n_vec++;
        if ({busy_s, done_s, neg_s, hun_s, ten_s, uni_s} !== 15'd0) begin
            n_err++; $display("FAIL rst_mid_clear got %b want 0", {busy_s, done_s, neg_s, hun_s, ten_s, uni_s});
        end
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_s || busy_s) seen++;
        end
        n_vec++;
        if (seen != 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d cycles active want 0", seen); end
        go_s(8'hFF);
        wait_done_s(lat);
        n_vec++;
        if (lat != 9 || {neg_s, hun_s, ten_s, uni_s} !== {1'b1, 12'h001}) begin
            n_err++; $display("FAIL rst_mid_after got lat=%0d %h want lat=9 1001", lat, {neg_s, hun_s, ten_s, uni_s});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_sweep;
        int lat;
        logic [12:0] exp;
        for (int v = 255; v >= 0; v--) begin
            exp = {1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            go_u(8'(v));
            wait_done_u(lat);
            n_vec++;
            if (lat != 9 || {neg_u, hun_u, ten_u, uni_u} !== exp) begin
                n_err++;
                $display("FAIL unsigned_%0d got lat=%0d %h want lat=9 %h", v, lat, {neg_u, hun_u, ten_u, uni_u}, exp);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_latency;
        test_signed_vectors;
        test_back_to_back;
        test_reset_mid;
        test_unsigned_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
